// File: rtl/true_dual_port_ram.sv
// Dual-port byte-enabled RAM with a power-up clear sequence, configurable read
// latency and read-during-write behaviour, and a cross-port collision flag.
module true_dual_port_ram #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned BYTE_W  = 8,
   parameter int unsigned RD_LAT  = 1,
   parameter int unsigned WR_MODE = 0
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      a_wr_en,
   input  logic                      a_rd_en,
   input  logic [ADDR_W-1:0]         a_addr,
   input  logic [WIDTH-1:0]          a_wdata,
   input  logic [WIDTH/BYTE_W-1:0]   a_be,
   output logic [WIDTH-1:0]          a_rdata,
   output logic                      a_rvalid,
   input  logic                      b_wr_en,
   input  logic                      b_rd_en,
   input  logic [ADDR_W-1:0]         b_addr,
   input  logic [WIDTH-1:0]          b_wdata,
   input  logic [WIDTH/BYTE_W-1:0]   b_be,
   output logic [WIDTH-1:0]          b_rdata,
   output logic                      b_rvalid,
   output logic                      init_busy,
   output logic                      collision
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned NB    = WIDTH / BYTE_W;

   if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
      $error("true_dual_port_ram: RD_LAT must be 1 or 2");
   end
   if ((BYTE_W == 0) || ((WIDTH % BYTE_W) != 0)) begin : g_bad_byte_w
      $error("true_dual_port_ram: WIDTH must be a multiple of BYTE_W");
   end
   if (WR_MODE > 1) begin : g_bad_wr_mode
      $error("true_dual_port_ram: WR_MODE must be 0 or 1");
   end

   typedef enum logic {INIT, READY} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_cnt;
   logic [ADDR_W-1:0]   w_cnt_nxt;
   logic                w_clr_en;

   logic [WIDTH-1:0]    r_mem [DEPTH];

   logic                w_ready;
   logic                w_a_we;
   logic                w_a_re;
   logic                w_b_we;
   logic                w_b_re;
   logic [WIDTH-1:0]    w_a_rd_word;
   logic [WIDTH-1:0]    w_b_rd_word;

   logic                r_a_v1;
   logic                r_b_v1;
   logic [WIDTH-1:0]    r_a_d1;
   logic [WIDTH-1:0]    r_b_d1;
   logic                r_collision;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clr_en    = 1'b0;
      case (r_state)
         INIT: begin
            w_clr_en  = 1'b1;
            w_cnt_nxt = r_cnt + ADDR_W'(1);
            if (&r_cnt) begin
               w_state_nxt = READY;
            end
         end
         READY: begin
            w_state_nxt = READY;
         end
         default: begin
            w_state_nxt = INIT;
         end
      endcase
   end

   assign w_ready   = (r_state == READY);
   assign init_busy = ~w_ready;
   assign w_a_we    = w_ready & a_wr_en;
   assign w_a_re    = w_ready & a_rd_en;
   assign w_b_we    = w_ready & b_wr_en;
   assign w_b_re    = w_ready & b_rd_en;

   // B lanes are scheduled first so A wins any lane both ports enable.
   always_ff @(posedge clk) begin
      if (w_clr_en) begin
         r_mem[r_cnt] <= '0;
      end else begin
         for (int unsigned k = 0; k < NB; k++) begin
            if (w_b_we && b_be[k]) begin
               r_mem[b_addr][k*BYTE_W +: BYTE_W] <= b_wdata[k*BYTE_W +: BYTE_W];
            end
            if (w_a_we && a_be[k]) begin
               r_mem[a_addr][k*BYTE_W +: BYTE_W] <= a_wdata[k*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Only the port's own write is merged; the other port's write stays invisible.
   always_comb begin
      w_a_rd_word = r_mem[a_addr];
      w_b_rd_word = r_mem[b_addr];
      if (WR_MODE == 1) begin
         for (int unsigned k = 0; k < NB; k++) begin
            if (w_a_we && a_be[k]) begin
               w_a_rd_word[k*BYTE_W +: BYTE_W] = a_wdata[k*BYTE_W +: BYTE_W];
            end
            if (w_b_we && b_be[k]) begin
               w_b_rd_word[k*BYTE_W +: BYTE_W] = b_wdata[k*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_a_v1      <= 1'b0;
         r_b_v1      <= 1'b0;
         r_a_d1      <= '0;
         r_b_d1      <= '0;
         r_collision <= 1'b0;
      end else begin
         r_a_v1 <= w_a_re;
         r_b_v1 <= w_b_re;
         if (w_a_re) begin
            r_a_d1 <= w_a_rd_word;
         end
         if (w_b_re) begin
            r_b_d1 <= w_b_rd_word;
         end
         r_collision <= w_ready && (a_addr == b_addr) &&
                        ((a_wr_en && (b_rd_en || b_wr_en)) ||
                         (b_wr_en && (a_rd_en || a_wr_en)));
      end
   end

   assign collision = r_collision;

   if (RD_LAT == 2) begin : g_lat2
      logic             r_a_v2;
      logic             r_b_v2;
      logic [WIDTH-1:0] r_a_d2;
      logic [WIDTH-1:0] r_b_d2;

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            r_a_v2 <= 1'b0;
            r_b_v2 <= 1'b0;
            r_a_d2 <= '0;
            r_b_d2 <= '0;
         end else begin
            r_a_v2 <= r_a_v1;
            r_b_v2 <= r_b_v1;
            if (r_a_v1) begin
               r_a_d2 <= r_a_d1;
            end
            if (r_b_v1) begin
               r_b_d2 <= r_b_d1;
            end
         end
      end

      assign a_rvalid = r_a_v2;
      assign b_rvalid = r_b_v2;
      assign a_rdata  = r_a_d2;
      assign b_rdata  = r_b_d2;
   end else begin : g_lat1
      assign a_rvalid = r_a_v1;
      assign b_rvalid = r_b_v1;
      assign a_rdata  = r_a_d1;
      assign b_rdata  = r_b_d1;
   end

endmodule

// File: tb/tb_true_dual_port_ram.sv
// Scoreboard bench: two RAM instances (read-first/latency 1, write-first/latency 2)
// share stimulus; an array-level reference model predicts every read and flag.
module tb_true_dual_port_ram;

   localparam int W     = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk  = 1'b0;
   logic          rstn = 1'b1;
   logic          a_wr_en, a_rd_en, b_wr_en, b_rd_en;
   logic [AW-1:0] a_addr, b_addr;
   logic [W-1:0]  a_wdata, b_wdata;
   logic [1:0]    a_be, b_be;

   logic [W-1:0]  a_rdata0, b_rdata0, a_rdata1, b_rdata1;
   logic          a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1;
   logic          init_busy0, init_busy1, collision0, collision1;

   true_dual_port_ram #(.WIDTH(W), .ADDR_W(AW), .BYTE_W(8), .RD_LAT(1), .WR_MODE(0)) u_dut0 (
      .clk(clk), .rstn(rstn),
      .a_wr_en(a_wr_en), .a_rd_en(a_rd_en), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
      .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
      .b_wr_en(b_wr_en), .b_rd_en(b_rd_en), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
      .b_rdata(b_rdata0), .b_rvalid(b_rvalid0),
      .init_busy(init_busy0), .collision(collision0)
   );

   true_dual_port_ram #(.WIDTH(W), .ADDR_W(AW), .BYTE_W(8), .RD_LAT(2), .WR_MODE(1)) u_dut1 (
      .clk(clk), .rstn(rstn),
      .a_wr_en(a_wr_en), .a_rd_en(a_rd_en), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
      .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
      .b_wr_en(b_wr_en), .b_rd_en(b_rd_en), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
      .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
      .init_busy(init_busy1), .collision(collision1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      int           due;
   } rd_t;

   // Queue index: 0 = dut0 port A, 1 = dut0 port B, 2 = dut1 port A, 3 = dut1 port B.
   rd_t          q[4][$];
   logic [W-1:0] last[4];
   logic [W-1:0] model[DEPTH];
   bit           coll_at[int];
   int           total     = 0;
   int           bad       = 0;
   int           cyc       = 0;
   int           since_rel = 0;

   function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] wd,
                                          input logic [1:0] be);
      logic [W-1:0] r;
      r = old;
      for (int k = 0; k < 2; k++) begin
         if (be[k]) r[k*8 +: 8] = wd[k*8 +: 8];
      end
      return r;
   endfunction

   task automatic chk_bit(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %0b want %0b", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_port(input int p, input logic v, input logic [W-1:0] d, input string nm);
      logic exp_v;
      rd_t  e;
      exp_v = (q[p].size() > 0) && (q[p][0].due == cyc);
      total++;
      if (v !== exp_v) begin
         bad++;
         $display("FAIL %s_rvalid cyc=%0d: got %0b want %0b", nm, cyc, v, exp_v);
      end
      if (exp_v) begin
         e = q[p].pop_front();
         last[p] = e.data;
      end
      while ((q[p].size() > 0) && (q[p][0].due < cyc)) void'(q[p].pop_front());
      total++;
      if (d !== last[p]) begin
         bad++;
         $display("FAIL %s_rdata cyc=%0d: got %h want %h", nm, cyc, d, last[p]);
      end
   endtask

   // Monitor: one sample per cycle, 1 time unit after the rising edge.
   initial begin
      logic exp_c;
      logic exp_b;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rstn) since_rel = 0;
         else       since_rel++;
         #1;
         chk_port(0, a_rvalid0, a_rdata0, "dut0_a");
         chk_port(1, b_rvalid0, b_rdata0, "dut0_b");
         chk_port(2, a_rvalid1, a_rdata1, "dut1_a");
         chk_port(3, b_rvalid1, b_rdata1, "dut1_b");
         exp_c = coll_at.exists(cyc);
         if (exp_c) coll_at.delete(cyc);
         chk_bit("dut0_collision", collision0, exp_c);
         chk_bit("dut1_collision", collision1, exp_c);
         exp_b = !rstn || (since_rel < DEPTH);
         chk_bit("dut0_init_busy", init_busy0, exp_b);
         chk_bit("dut1_init_busy", init_busy1, exp_b);
      end
   end

   // One cycle of stimulus, applied on the falling edge; expectations are
   // queued before the rising edge that samples the request.
   task automatic drive(input logic aw, input logic ar, input logic [AW-1:0] aa,
                        input logic [W-1:0] ad, input logic [1:0] abe,
                        input logic bw, input logic br, input logic [AW-1:0] ba,
                        input logic [W-1:0] bd, input logic [1:0] bbe);
      logic [W-1:0] oa, ob;
      rd_t          e;
      @(negedge clk);
      a_wr_en = aw; a_rd_en = ar; a_addr = aa; a_wdata = ad; a_be = abe;
      b_wr_en = bw; b_rd_en = br; b_addr = ba; b_wdata = bd; b_be = bbe;
      if (since_rel >= DEPTH) begin
         oa = model[aa];
         ob = model[ba];
         if (ar) begin
            e.data = oa;                              e.due = cyc + 1; q[0].push_back(e);
            e.data = aw ? merge(oa, ad, abe) : oa;    e.due = cyc + 2; q[2].push_back(e);
         end
         if (br) begin
            e.data = ob;                              e.due = cyc + 1; q[1].push_back(e);
            e.data = bw ? merge(ob, bd, bbe) : ob;    e.due = cyc + 2; q[3].push_back(e);
         end
         if ((aa == ba) && ((aw && (br || bw)) || (bw && (ar || aw)))) coll_at[cyc + 1] = 1'b1;
         if (bw) model[ba] = merge(model[ba], bd, bbe);
         if (aw) model[aa] = merge(model[aa], ad, abe);
      end else begin
         for (int i = 0; i < DEPTH; i++) model[i] = '0;
      end
   endtask

   task automatic rnd(input int amax);
      drive(1'($urandom), 1'($urandom), AW'($urandom_range(0, amax)), W'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), AW'($urandom_range(0, amax)), W'($urandom), 2'($urandom));
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rstn = 1'b0;
      for (int p = 0; p < 4; p++) begin
         q[p].delete();
         last[p] = '0;
      end
      coll_at.delete();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         a_wr_en = 1'b1; a_rd_en = 1'b1; a_addr = AW'($urandom); a_wdata = W'($urandom); a_be = 2'b11;
         b_wr_en = 1'b1; b_rd_en = 1'b1; b_addr = AW'($urandom); b_wdata = W'($urandom); b_be = 2'b11;
      end
      rstn = 1'b1;
   endtask

   task automatic read_all();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 1'b1, AW'(i), '0, '0, 1'b0, 1'b1, AW'(DEPTH - 1 - i), '0, '0);
      end
   endtask

   task automatic finish_init();
      for (int g = 0; (g < 4 * DEPTH) && (since_rel < DEPTH); g++) rnd(DEPTH - 1);
   endtask

   initial begin
      rstn    = 1'b0;
      a_wr_en = 1'b0; a_rd_en = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
      b_wr_en = 1'b0; b_rd_en = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
      do_reset(3);
      finish_init();
      read_all();

      drive(1'b1, 1'b0, 4'd3, 16'h1234, 2'b11, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, 4'd3, 16'hBEEF, 2'b10, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b0, 1'b1, 4'd3, '0, '0, 1'b0, 1'b1, 4'd3, '0, '0);
      drive(1'b1, 1'b0, 4'd3, 16'hFFFF, 2'b00, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b0, 1'b1, 4'd3, '0, '0, 1'b0, 1'b0, '0, '0, '0);

      drive(1'b1, 1'b0, 4'd5, 16'h0011, 2'b01, 1'b1, 1'b0, 4'd5, 16'h0022, 2'b01);
      drive(1'b1, 1'b0, 4'd6, 16'hAB11, 2'b11, 1'b1, 1'b0, 4'd6, 16'hCD22, 2'b10);
      drive(1'b0, 1'b1, 4'd5, '0, '0, 1'b0, 1'b1, 4'd6, '0, '0);

      drive(1'b1, 1'b0, 4'd7, 16'h00AA, 2'b11, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b1, 4'd7, 16'h0055, 2'b11, 1'b0, 1'b1, 4'd7, '0, '0);
      drive(1'b0, 1'b1, 4'd7, '0, '0, 1'b1, 1'b1, 4'd7, 16'h7766, 2'b01);
      drive(1'b0, 1'b1, 4'd7, '0, '0, 1'b0, 1'b0, '0, '0, '0);
      idle();

      repeat (300) rnd(3);
      repeat (100) rnd(DEPTH - 1);

      drive(1'b0, 1'b1, 4'd2, '0, '0, 1'b0, 1'b1, 4'd9, '0, '0);
      do_reset(2);
      for (int g = 0; (g < 4 * DEPTH) && (since_rel < 8); g++) rnd(DEPTH - 1);
      do_reset(2);
      finish_init();
      read_all();

      repeat (200) rnd(3);
      repeat (4) idle();

      for (int p = 0; p < 4; p++) begin
         total++;
         if (q[p].size() != 0) begin
            bad++;
            $display("FAIL drain_q%0d: got %0d pending want 0", p, q[p].size());
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
